// File: rtl/mouse_regs_pkg.sv
// Shared definitions for the PS/2 mouse APB register block: register byte offsets,
// CTRL/STATUS bit positions and the packed CTRL register layout.
package mouse_regs_pkg;

  // Byte offsets within the 16-byte register window.
  localparam logic [3:0] POS_OFFS    = 4'h0;
  localparam logic [3:0] BTN_OFFS    = 4'h4;
  localparam logic [3:0] CTRL_OFFS   = 4'h8;
  localparam logic [3:0] STATUS_OFFS = 4'hC;

  // CTRL bit indices.
  localparam int unsigned CTRL_BTN_IRQ_EN_BIT  = 0;
  localparam int unsigned CTRL_MOVE_IRQ_EN_BIT = 1;

  // STATUS bit indices.
  localparam int unsigned STATUS_BTN_PENDING_BIT = 0;
  localparam int unsigned STATUS_MOVED_BIT       = 1;

  typedef struct packed {
    logic move_irq_en;
    logic btn_irq_en;
  } ctrl_t;

endpackage

// File: rtl/apb_mouse_regs.sv
// Zero-wait-state APB3 slave exposing the mouse cursor position and sticky buttons.
//
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   PADDR..PSLVERR      APB3 slave port (PREADY tied high)
//   x_pos_i, y_pos_i    cursor position from the mouse wrapper
//   btnm_i              sticky buttons {middle,right,left} from the mouse wrapper
//   ack_o               one-cycle pulse clearing the wrapper's sticky buttons
//   irq_o               registered level interrupt (button and/or movement)
module apb_mouse_regs
  import mouse_regs_pkg::*;
#(
  parameter int unsigned X_POS_WIDTH    = 10,
  parameter int unsigned Y_POS_WIDTH    = 9,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [X_POS_WIDTH:0]      x_pos_i,
  input  logic [Y_POS_WIDTH:0]      y_pos_i,
  input  logic [2:0]                btnm_i,
  output logic                      ack_o,
  output logic                      irq_o
);

  if (X_POS_WIDTH + 1 > 16) begin : gen_x_width_err
    $error("apb_mouse_regs: X_POS_WIDTH+1 must not exceed 16");
  end
  if (Y_POS_WIDTH + 1 > 16) begin : gen_y_width_err
    $error("apb_mouse_regs: Y_POS_WIDTH+1 must not exceed 16");
  end
  if (APB_ADDR_WIDTH < 4) begin : gen_addr_width_err
    $error("apb_mouse_regs: APB_ADDR_WIDTH must be at least 4");
  end

  logic        access;
  logic        addr_ok;
  logic [3:0]  reg_sel;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] pos_word;

  ctrl_t                ctrl_q, ctrl_d;
  logic                 moved_q, moved_d;
  logic [X_POS_WIDTH:0] prev_x_q;
  logic [Y_POS_WIDTH:0] prev_y_q;
  logic                 ack_q, ack_d;
  logic                 irq_q, irq_d;

  // Byte lanes within a word are not decoded.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:2]};

  assign access  = PSEL & PENABLE;
  assign reg_sel = {PADDR[3:2], 2'b00};

  // Anything above the 16-byte window is an unmapped access.
  if (APB_ADDR_WIDTH > 4) begin : gen_addr_hi
    assign addr_ok = ~|PADDR[APB_ADDR_WIDTH-1:4];
  end else begin : gen_addr_no_hi
    assign addr_ok = 1'b1;
  end

  assign rd_en = access & ~PWRITE & addr_ok;
  assign wr_en = access &  PWRITE & addr_ok;

  always_comb begin
    pos_word                      = '0;
    pos_word[X_POS_WIDTH:0]       = x_pos_i;
    pos_word[16 +: Y_POS_WIDTH+1] = y_pos_i;
  end

  // Read path: purely combinational, zero outside the access cycle.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      if (!addr_ok) begin
        PSLVERR = 1'b1;
      end else if (!PWRITE) begin
        case (reg_sel)
          POS_OFFS:  PRDATA = pos_word;
          BTN_OFFS:  PRDATA = {29'b0, btnm_i};
          CTRL_OFFS: begin
            PRDATA[CTRL_BTN_IRQ_EN_BIT]  = ctrl_q.btn_irq_en;
            PRDATA[CTRL_MOVE_IRQ_EN_BIT] = ctrl_q.move_irq_en;
          end
          STATUS_OFFS: begin
            PRDATA[STATUS_BTN_PENDING_BIT] = |btnm_i;
            PRDATA[STATUS_MOVED_BIT]       = moved_q;
          end
          default: PRDATA = '0;
        endcase
      end
    end
  end

  assign PREADY = 1'b1;

  always_comb begin
    ctrl_d  = ctrl_q;
    moved_d = moved_q;
    ack_d   = rd_en && (reg_sel == BTN_OFFS);

    if (wr_en && (reg_sel == CTRL_OFFS)) begin
      ctrl_d.btn_irq_en  = PWDATA[CTRL_BTN_IRQ_EN_BIT];
      ctrl_d.move_irq_en = PWDATA[CTRL_MOVE_IRQ_EN_BIT];
    end

    if (wr_en && (reg_sel == STATUS_OFFS) && PWDATA[STATUS_MOVED_BIT]) begin
      moved_d = 1'b0;
    end
    // A fresh move overrides a coincident W1C so the event is never lost.
    if ((x_pos_i != prev_x_q) || (y_pos_i != prev_y_q)) begin
      moved_d = 1'b1;
    end

    irq_d = (ctrl_q.btn_irq_en & (|btnm_i)) | (ctrl_q.move_irq_en & moved_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q   <= '0;
      moved_q  <= 1'b0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      moved_q  <= moved_d;
      prev_x_q <= x_pos_i;
      prev_y_q <= y_pos_i;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  assign ack_o = ack_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_apb_mouse_regs.sv
// Directed bench for apb_mouse_regs: expected values are queued on a scoreboard as each
// step is driven and popped when the matching DUT output is sampled.
module tb_apb_mouse_regs;

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [XW:0]   x_pos;
  logic [YW:0]   y_pos;
  logic [2:0]    btnm;
  logic          ack;
  logic          irq;

  apb_mouse_regs #(
    .X_POS_WIDTH   (XW),
    .Y_POS_WIDTH   (YW),
    .APB_ADDR_WIDTH(AW)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .PADDR  (paddr),
    .PWDATA (pwdata),
    .PWRITE (pwrite),
    .PSEL   (psel),
    .PENABLE(penable),
    .PRDATA (prdata),
    .PREADY (pready),
    .PSLVERR(pslverr),
    .x_pos_i(x_pos),
    .y_pos_i(y_pos),
    .btnm_i (btnm),
    .ack_o  (ack),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0x%08h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_b);
    push_exp(tag, {31'b0, exp_b});
    check({31'b0, obs});
  endtask

  task automatic apb_read(input logic [AW-1:0] a, input string tag,
                          input logic [31:0] exp_d, input logic exp_err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    push_exp({tag, "_setup_prdata"}, 32'h0);
    @(negedge clk);
    check(prdata);
    @(posedge clk); #1;
    penable = 1'b1;
    push_exp({tag, "_prdata"}, exp_d);
    push_exp({tag, "_pslverr"}, {31'b0, exp_err});
    @(negedge clk);
    check(prdata);
    check({31'b0, pslverr});
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // bump_x changes x_pos at the start of the access cycle to coincide with the write.
  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d, input string tag,
                           input logic exp_err, input bit bump_x);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    if (bump_x) x_pos = x_pos + 1'b1;
    push_exp({tag, "_pslverr"}, {31'b0, exp_err});
    @(negedge clk);
    check({31'b0, pslverr});
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    x_pos = '0; y_pos = '0; btnm = '0;
    #2 rstn = 1'b0;
    #1;
    check_bit("rst_ack", ack, 1'b0);
    check_bit("rst_irq", irq, 1'b0);
    check_bit("rst_pslverr", pslverr, 1'b0);
    check_bit("rst_pready", pready, 1'b1);
    push_exp("rst_prdata", 32'h0);
    check(prdata);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // All registers read zero out of reset.
    apb_read(12'h000, "pos0", 32'h0, 1'b0);
    apb_read(12'h004, "btn0", 32'h0, 1'b0);
    check_bit("btn0_ack", ack, 1'b1);
    apb_read(12'h008, "ctrl0", 32'h0, 1'b0);
    apb_read(12'h00C, "status0", 32'h0, 1'b0);
    check_bit("idle_irq", irq, 1'b0);
    check_bit("idle_ack", ack, 1'b0);

    // Position read.
    x_pos = 11'h27F; y_pos = 10'h1DF;
    apb_read(12'h000, "pos", 32'h01DF027F, 1'b0);
    apb_read(12'h00C, "status_mv_init", 32'h2, 1'b0);
    apb_write(12'h00C, 32'h2, "w1c_init", 1'b0, 1'b0);
    apb_read(12'h00C, "status_clr_init", 32'h0, 1'b0);

    // Button interrupt and acknowledge handshake.
    btnm = 3'b101;
    apb_write(12'h008, 32'h1, "ctrl_btn", 1'b0, 1'b0);
    check_bit("irq_btn_lat0", irq, 1'b0);
    @(posedge clk); #1;
    check_bit("irq_btn_lat1", irq, 1'b1);
    apb_read(12'h00C, "status_btn", 32'h1, 1'b0);
    apb_read(12'h004, "btn", 32'h5, 1'b0);
    check_bit("btn_ack_pulse", ack, 1'b1);
    @(posedge clk); #1;
    btnm = 3'b000;
    check_bit("btn_ack_drop", ack, 1'b0);
    check_bit("irq_btn_hold", irq, 1'b1);
    @(posedge clk); #1;
    check_bit("irq_btn_clear", irq, 1'b0);

    // Movement interrupt and W1C.
    apb_write(12'h008, 32'h2, "ctrl_move", 1'b0, 1'b0);
    x_pos = 11'h280;
    apb_read(12'h00C, "status_moved", 32'h2, 1'b0);
    check_bit("irq_move", irq, 1'b1);
    apb_write(12'h00C, 32'h2, "w1c", 1'b0, 1'b0);
    @(posedge clk); #1;
    check_bit("irq_move_clear", irq, 1'b0);
    apb_read(12'h00C, "status_cleared", 32'h0, 1'b0);

    // W1C coincident with a new move: set wins.
    apb_write(12'h00C, 32'h2, "w1c_race", 1'b0, 1'b1);
    apb_read(12'h00C, "status_race", 32'h2, 1'b0);
    check_bit("irq_race", irq, 1'b1);
    apb_write(12'h00C, 32'h2, "w1c_final", 1'b0, 1'b0);
    apb_read(12'h00C, "status_final", 32'h0, 1'b0);

    // Unmapped accesses, ignored writes, RAZ/WI bits.
    apb_read(12'h010, "rd_unmapped", 32'h0, 1'b1);
    apb_write(12'h014, 32'h3, "wr_unmapped", 1'b1, 1'b0);
    apb_read(12'h008, "ctrl_kept", 32'h2, 1'b0);
    apb_write(12'h000, 32'hDEADBEEF, "wr_pos", 1'b0, 1'b0);
    apb_read(12'h000, "pos_kept", 32'h01DF0281, 1'b0);
    apb_write(12'h008, 32'hFFFFFFFF, "ctrl_all", 1'b0, 1'b0);
    apb_read(12'h008, "ctrl_rb", 32'h3, 1'b0);
    check_bit("irq_quiet", irq, 1'b0);

    // Reset right after a BTN read drops the pending ack.
    btnm = 3'b010;
    apb_read(12'h004, "btn_pre_rst", 32'h2, 1'b0);
    check_bit("pre_rst_ack", ack, 1'b1);
    check_bit("pre_rst_irq", irq, 1'b1);
    rstn = 1'b0;
    #1;
    check_bit("mid_rst_ack", ack, 1'b0);
    check_bit("mid_rst_irq", irq, 1'b0);
    btnm = '0; x_pos = '0; y_pos = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    apb_read(12'h008, "ctrl_after_rst", 32'h0, 1'b0);
    apb_read(12'h00C, "status_after_rst", 32'h0, 1'b0);
    check_bit("post_rst_irq", irq, 1'b0);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
